// File: rtl/mem_ctrl_pkg.sv
// Shared FSM state encoding, default parameters and a counter-width helper for the SRAM controller.
// Latency: none (types and constants only).
// Backpressure: n/a.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_SRAM_W     = 16;
  localparam int DEF_SRAM_AW    = 18;
  localparam int DEF_LINE_WORDS = 1;
  localparam int DEF_WAIT       = 5;
  localparam int DEF_BASE_ADDR  = 1024;

  // Counter width for a 0..n-1 range; a single-value range still gets one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_beat_timer.sv
// Beat sequencer: wait_cnt steps 0..WAIT-1 inside a beat, beat_cnt steps 0..BEATS-1 across the request.
// Latency: beat_last on the final cycle of each beat, req_last on the final cycle of the final beat.
// Backpressure: none; counts only while en is high and is held at zero otherwise.
module sram_beat_timer
  import mem_ctrl_pkg::*;
#(
  parameter int WAIT   = DEF_WAIT,
  parameter int BEATS  = 2,
  parameter int WAIT_W = cnt_w(WAIT),
  parameter int BEAT_W = cnt_w(BEATS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [WAIT_W-1:0] wait_cnt,
  output logic [BEAT_W-1:0] beat_cnt,
  output logic              beat_last,
  output logic              req_last
);

  assign beat_last = (wait_cnt == WAIT_W'(WAIT - 1));
  assign req_last  = beat_last && (beat_cnt == BEAT_W'(BEATS - 1));

  // Advance within a beat, roll to the next beat, and rewind to zero after the last beat.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      wait_cnt <= '0;
      beat_cnt <= '0;
    end else if (beat_last) begin
      wait_cnt <= '0;
      beat_cnt <= req_last ? '0 : beat_cnt + 1'b1;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_sram_ctrl.sv
// Pipeline-to-async-SRAM bridge: one line request is split into B beats of WAIT cycles each, low half first.
// Latency: ready returns B*WAIT+1 cycles after a request is first seen in IDLE (1 cycle for a range error).
// Backpressure: ready low freezes the pipeline; requests are taken only in IDLE. MEM_SRAM_CTRL_RANGE_CHECK_EN enables the out-of-range error path.
module mem_sram_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int SRAM_W     = DEF_SRAM_W,
  parameter int SRAM_AW    = DEF_SRAM_AW,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int WAIT       = DEF_WAIT,
  parameter int BASE_ADDR  = DEF_BASE_ADDR
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic                         rd_en,
  input  logic [31:0]                  addr,
  input  logic [DATA_W*LINE_WORDS-1:0] wdata,
  output logic [DATA_W*LINE_WORDS-1:0] rdata,
  output logic                         ready,
  output logic                         err,
  inout  wire  [SRAM_W-1:0]            SRAM_DQ,
  output logic [SRAM_AW-1:0]           SRAM_ADDR,
  output logic                         SRAM_UB_N,
  output logic                         SRAM_LB_N,
  output logic                         SRAM_WE_N,
  output logic                         SRAM_CE_N,
  output logic                         SRAM_OE_N
);

  localparam int B       = LINE_WORDS * DATA_W / SRAM_W;
  localparam int BEAT_W  = cnt_w(B);
  localparam int WAIT_W  = cnt_w(WAIT);
  localparam int BYTE_SH = $clog2(SRAM_W / 8);

  state_t                   state;
  logic                     op_wr_q;
  logic                     we_n_q;
  logic                     err_q;
  logic [SRAM_AW-1:0]       line_base_q;
  logic [B-1:0][SRAM_W-1:0] wline_q;
  logic [B-1:0][SRAM_W-1:0] rline_q;

  logic [WAIT_W-1:0]        wait_cnt;
  logic [BEAT_W-1:0]        beat_cnt;
  logic                     beat_last;
  logic                     req_last;

  // Byte address -> SRAM word index, aligned down to the first beat of the line (B is a power of 2).
  logic [31:0] offset;
  logic [31:0] word_idx;
  logic [31:0] line_idx;
  logic        out_of_range;
  logic        unused_hi;

  assign offset    = addr - 32'(BASE_ADDR);
  assign word_idx  = offset >> BYTE_SH;
  assign line_idx  = word_idx & ~32'(B - 1);
  // Bits above the SRAM address width wrap away in the default build.
  assign unused_hi = ^line_idx[31:SRAM_AW];

`ifdef MEM_SRAM_CTRL_RANGE_CHECK_EN
  assign out_of_range = (addr < 32'(BASE_ADDR)) || ((word_idx >> SRAM_AW) != 32'd0);
`else
  assign out_of_range = 1'b0;
`endif

  sram_beat_timer #(
    .WAIT  (WAIT),
    .BEATS (B)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .en        (state == ACCESS),
    .wait_cnt  (wait_cnt),
    .beat_cnt  (beat_cnt),
    .beat_last (beat_last),
    .req_last  (req_last)
  );

  // Request FSM: latch the request in IDLE, run the beats in ACCESS, hand back in a one-cycle DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      op_wr_q     <= 1'b0;
      we_n_q      <= 1'b1;
      err_q       <= 1'b0;
      line_base_q <= '0;
      wline_q     <= '0;
      rline_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_en || rd_en) begin
            op_wr_q <= wr_en;
            if (out_of_range) begin
              // No SRAM cycle at all: address and data registers keep their old contents.
              state <= DONE;
              err_q <= 1'b1;
            end else begin
              state       <= ACCESS;
              line_base_q <= line_idx[SRAM_AW-1:0];
              wline_q     <= wdata;
              we_n_q      <= ~wr_en;
            end
          end
        end
        ACCESS: begin
          // Sample read data at the end of the beat, when the SRAM has had the full WAIT window.
          if (!op_wr_q && beat_last) begin
            rline_q[beat_cnt] <= SRAM_DQ;
          end
          if (req_last) begin
            state  <= DONE;
            we_n_q <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          err_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ready     = ((state == IDLE) && !rd_en && !wr_en) || (state == DONE);
  assign err       = err_q;
  assign rdata     = rline_q;
  assign SRAM_ADDR = line_base_q + SRAM_AW'(beat_cnt);
  assign SRAM_WE_N = we_n_q;
  assign SRAM_DQ   = we_n_q ? {SRAM_W{1'bz}} : wline_q[beat_cnt];
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

endmodule
